// File: rtl/axil_strobe_merge_if.sv
// AXI-lite style read/write channel between the DPM front end and the strobe merge.
// Word-addressed, single outstanding access per direction.
interface axil_strobe_merge_if #(
  parameter int ADDR_W = 18
) ();
  logic              rstart;
  logic [ADDR_W-1:0] raddr;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              wstart;
  logic [ADDR_W-1:0] waddr;
  logic              bready;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;

  modport master (
    output rstart, raddr, rready, wstart, waddr, bready,
    input  rdata, rresp, rvalid, wready, bresp, bvalid
  );

  modport slave (
    input  rstart, raddr, rready, wstart, waddr, bready,
    output rdata, rresp, rvalid, wready, bresp, bvalid
  );
endinterface

// File: rtl/axil_strobe_merge.sv
// Fans one AXI-lite read/write channel out to NUM_TGT strobe/ack register targets.
// Independent read and write FSMs with ack timeout, DECERR/SLVERR and a saturating error count.
module axil_strobe_merge #(
  parameter int NUM_TGT = 5,
  parameter int ADDR_W  = 18,
  parameter int SEL_LSB = 8,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                   axilClk,
  input  logic                   axilRstN,
  axil_strobe_merge_if.slave     bus,
  output logic [NUM_TGT-1:0]     tgt_rstr,
  input  logic [NUM_TGT-1:0]     tgt_rack,
  input  logic [32*NUM_TGT-1:0]  tgt_din,
  output logic [NUM_TGT-1:0]     tgt_wstr,
  input  logic [NUM_TGT-1:0]     tgt_wack,
  output logic [15:0]            err_count
);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_e;

  rstate_e          rs_q, rs_d;
  wstate_e          ws_q, ws_d;
  logic [SEL_W-1:0] rsel_q, rsel_d, wsel_q, wsel_d, rsel_in, wsel_in;
  logic [15:0]      rtmr_q, rtmr_d, wtmr_q, wtmr_d;
  logic [31:0]      rdata_q, rdata_d, rdin;
  logic [1:0]       rresp_q, rresp_d, bresp_q, bresp_d;
  logic             wready_q, wready_d;
  logic             rhit, whit, rerr, werr;
  logic [15:0]      err_q, err_d;
  logic [16:0]      err_sum;
  logic [ADDR_W-1:0] raddr, waddr;
  logic             unused_addr;

  assign raddr   = bus.raddr;
  assign waddr   = bus.waddr;
  assign rsel_in = raddr[SEL_LSB +: SEL_W];
  assign wsel_in = waddr[SEL_LSB +: SEL_W];
  // Only the target-select field of the word address is decoded.
  assign unused_addr = ^{raddr, waddr};

  // Strobes come from registered state only, so they are one-hot and glitch-free.
  assign tgt_rstr = (rs_q == R_WAIT) ? (NUM_TGT'(1) << rsel_q) : '0;
  assign tgt_wstr = (ws_q == W_WAIT) ? (NUM_TGT'(1) << wsel_q) : '0;
  assign rhit     = |(tgt_rack & tgt_rstr);
  assign whit     = |(tgt_wack & tgt_wstr);

  always_comb begin
    rdin = '0;
    for (int i = 0; i < NUM_TGT; i++)
      if (rsel_q == SEL_W'(i)) rdin = tgt_din[32*i +: 32];
  end

  always_comb begin
    rs_d    = rs_q;
    rsel_d  = rsel_q;
    rtmr_d  = rtmr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rerr    = 1'b0;
    case (rs_q)
      R_IDLE: if (bus.rstart) begin
        rsel_d = rsel_in;
        rtmr_d = '0;
        if (32'(rsel_in) < NUM_TGT) rs_d = R_WAIT;
        else begin
          rs_d    = R_RESP;
          rdata_d = 32'hDEADDEAD;
          rresp_d = 2'b11;
          rerr    = 1'b1;
        end
      end
      R_WAIT: begin
        rtmr_d = rtmr_q + 16'd1;
        if (rhit) begin
          rs_d    = R_RESP;
          rdata_d = rdin;
          rresp_d = 2'b00;
        end else if (rtmr_q == TMO_LAST) begin
          rs_d    = R_RESP;
          rdata_d = 32'hDEAD0000 | 32'(rsel_q);
          rresp_d = 2'b10;
          rerr    = 1'b1;
        end
      end
      R_RESP:  if (bus.rready) rs_d = R_IDLE;
      default: rs_d = R_IDLE;
    endcase
  end

  always_comb begin
    ws_d     = ws_q;
    wsel_d   = wsel_q;
    wtmr_d   = wtmr_q;
    bresp_d  = bresp_q;
    wready_d = 1'b0;
    werr     = 1'b0;
    case (ws_q)
      W_IDLE: if (bus.wstart) begin
        wsel_d   = wsel_in;
        wtmr_d   = '0;
        wready_d = 1'b1;
        if (32'(wsel_in) < NUM_TGT) ws_d = W_WAIT;
        else begin
          ws_d    = W_RESP;
          bresp_d = 2'b11;
          werr    = 1'b1;
        end
      end
      W_WAIT: begin
        wtmr_d = wtmr_q + 16'd1;
        if (whit) begin
          ws_d    = W_RESP;
          bresp_d = 2'b00;
        end else if (wtmr_q == TMO_LAST) begin
          ws_d    = W_RESP;
          bresp_d = 2'b10;
          werr    = 1'b1;
        end
      end
      W_RESP:  if (bus.bready) ws_d = W_IDLE;
      default: ws_d = W_IDLE;
    endcase
  end

  // Both directions may flag an error on the same edge, hence the two-term add.
  assign err_sum = {1'b0, err_q} + 17'(rerr) + 17'(werr);
  assign err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  always_ff @(posedge axilClk) begin
    if (!axilRstN) begin
      rs_q     <= R_IDLE;
      ws_q     <= W_IDLE;
      rsel_q   <= '0;
      wsel_q   <= '0;
      rtmr_q   <= '0;
      wtmr_q   <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      bresp_q  <= '0;
      wready_q <= 1'b0;
      err_q    <= '0;
    end else begin
      rs_q     <= rs_d;
      ws_q     <= ws_d;
      rsel_q   <= rsel_d;
      wsel_q   <= wsel_d;
      rtmr_q   <= rtmr_d;
      wtmr_q   <= wtmr_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      bresp_q  <= bresp_d;
      wready_q <= wready_d;
      err_q    <= err_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rresp  = rresp_q;
  assign bus.rvalid = (rs_q == R_RESP);
  assign bus.bresp  = bresp_q;
  assign bus.bvalid = (ws_q == W_RESP);
  assign bus.wready = wready_q;
  assign err_count  = err_q;
endmodule

// File: tb/tb_axil_strobe_merge.sv
// Directed plus randomized bench for axil_strobe_merge; expectations come from a
// transaction-level model (latency/response/strobe length derived from select and ack delay).
module tb_axil_strobe_merge;
  localparam int NUM_TGT = 5;
  localparam int ADDR_W  = 18;
  localparam int SEL_LSB = 8;
  localparam int SEL_W   = 3;
  localparam int TIMEOUT = 8;
  localparam int NOACK   = 1000;

  logic                  axilClk, axilRstN;
  logic [NUM_TGT-1:0]    tgt_rstr, tgt_rack, tgt_wstr, tgt_wack;
  logic [32*NUM_TGT-1:0] tgt_din;
  logic [15:0]           err_count;

  int tests = 0;
  int fails = 0;
  int exp_err = 0;

  axil_strobe_merge_if #(.ADDR_W(ADDR_W)) m ();

  axil_strobe_merge #(
    .NUM_TGT(NUM_TGT), .ADDR_W(ADDR_W), .SEL_LSB(SEL_LSB), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .axilClk(axilClk), .axilRstN(axilRstN), .bus(m.slave),
    .tgt_rstr(tgt_rstr), .tgt_rack(tgt_rack), .tgt_din(tgt_din),
    .tgt_wstr(tgt_wstr), .tgt_wack(tgt_wack), .err_count(err_count)
  );

  initial axilClk = 1'b0;
  always #5 axilClk = ~axilClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] mkaddr(input int s);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom);
    a[SEL_LSB +: SEL_W] = SEL_W'(s);
    return a;
  endfunction

  // One read and/or write access; d = strobe cycles before the target acks, hold = extra
  // response cycles with ready low.
  task automatic run(input bit ren, input int rsel, input int rd, input int rhold,
                     input bit wen, input int wsel, input int wd, input int whold);
    bit en[2], done[2];
    int sel[2], d[2], hold[2], vcyc[2], scnt[2], bad[2], unst[2], hcnt[2];
    logic [1:0]  rsp0[2];
    logic [31:0] dat0;
    int cyc, wrdy_cnt, wrdy_first, exp_lat, exp_str;
    logic [1:0]  exp_rsp;
    logic [31:0] exp_dat;
    string nm;
    en[0] = ren; sel[0] = rsel; d[0] = rd; hold[0] = rhold;
    en[1] = wen; sel[1] = wsel; d[1] = wd; hold[1] = whold;
    for (int ch = 0; ch < 2; ch++) begin
      done[ch] = !en[ch]; vcyc[ch] = -1; scnt[ch] = 0; bad[ch] = 0; unst[ch] = 0; hcnt[ch] = 0;
      rsp0[ch] = '0;
    end
    dat0 = '0; wrdy_cnt = 0; wrdy_first = -1; cyc = 0;
    @(negedge axilClk);
    m.rstart = ren; m.raddr = mkaddr(rsel);
    m.wstart = wen; m.waddr = mkaddr(wsel);
    while (!(done[0] && done[1]) && cyc < 100) begin
      @(negedge axilClk);
      cyc++;
      m.rstart = 1'b0; m.wstart = 1'b0;
      m.raddr = ADDR_W'($urandom); m.waddr = ADDR_W'($urandom);
      if (m.wready) begin
        wrdy_cnt++;
        if (wrdy_first < 0) wrdy_first = cyc;
      end
      for (int ch = 0; ch < 2; ch++) begin
        logic [NUM_TGT-1:0] str, oh, ackv;
        logic vld, rdy;
        logic [1:0] rsp;
        str = ch ? tgt_wstr : tgt_rstr;
        vld = ch ? m.bvalid : m.rvalid;
        rsp = ch ? m.bresp : m.rresp;
        oh  = NUM_TGT'(1) << sel[ch];
        ackv = NUM_TGT'($urandom) & ~oh;
        rdy = 1'b0;
        if (!en[ch]) begin
          if (str != '0 || vld) bad[ch]++;
        end else if (!done[ch]) begin
          if (str != '0) begin
            if (str !== oh) bad[ch]++;
            else begin
              if (scnt[ch] == d[ch]) ackv = ackv | oh;
              scnt[ch]++;
            end
          end
          if (vld) begin
            if (vcyc[ch] < 0) begin
              vcyc[ch] = cyc; rsp0[ch] = rsp;
              if (ch == 0) dat0 = m.rdata;
            end else if (rsp !== rsp0[ch] || (ch == 0 && m.rdata !== dat0)) unst[ch]++;
            hcnt[ch]++;
            rdy = (hcnt[ch] > hold[ch]);
          end else if (vcyc[ch] >= 0) done[ch] = 1'b1;
        end
        if (ch == 0) begin tgt_rack = ackv; m.rready = rdy; end
        else begin tgt_wack = ackv; m.bready = rdy; end
      end
    end
    chk("access completes within budget", 32'(done[0] && done[1]), 32'd1);
    for (int ch = 0; ch < 2; ch++) begin
      nm = ch ? "wr" : "rd";
      chk({nm, " no stray strobe/valid"}, 32'(bad[ch]), 32'd0);
      if (en[ch]) begin
        if (sel[ch] >= NUM_TGT) begin
          exp_lat = 1; exp_str = 0; exp_rsp = 2'b11; exp_dat = 32'hDEADDEAD; exp_err++;
        end else if (d[ch] < TIMEOUT) begin
          exp_lat = d[ch] + 2; exp_str = d[ch] + 1; exp_rsp = 2'b00;
          exp_dat = tgt_din[32*sel[ch] +: 32];
        end else begin
          exp_lat = TIMEOUT + 1; exp_str = TIMEOUT; exp_rsp = 2'b10;
          exp_dat = 32'hDEAD0000 | 32'(sel[ch]); exp_err++;
        end
        chk({nm, " valid latency"}, 32'(vcyc[ch]), 32'(exp_lat));
        chk({nm, " strobe cycles"}, 32'(scnt[ch]), 32'(exp_str));
        chk({nm, " resp"}, 32'(rsp0[ch]), 32'(exp_rsp));
        chk({nm, " stable while valid"}, 32'(unst[ch]), 32'd0);
        if (ch == 0) chk("rd data", dat0, exp_dat);
      end
    end
    chk("wready pulse count", 32'(wrdy_cnt), wen ? 32'd1 : 32'd0);
    if (wen) chk("wready pulse cycle", 32'(wrdy_first), 32'd1);
    if (exp_err > 65535) exp_err = 65535;
    chk("err_count", 32'(err_count), 32'(exp_err));
  endtask

  initial begin
    axilRstN = 1'b0;
    m.rstart = 1'b0; m.raddr = '0; m.rready = 1'b0;
    m.wstart = 1'b0; m.waddr = '0; m.bready = 1'b0;
    tgt_rack = '0; tgt_wack = '0;
    for (int i = 0; i < NUM_TGT; i++) tgt_din[32*i +: 32] = $urandom;
    repeat (2) @(negedge axilClk);
    chk("reset rvalid", 32'(m.rvalid), 32'd0);
    chk("reset bvalid", 32'(m.bvalid), 32'd0);
    chk("reset wready", 32'(m.wready), 32'd0);
    chk("reset rdata", m.rdata, 32'd0);
    chk("reset resp", 32'({m.rresp, m.bresp}), 32'd0);
    chk("reset strobes", 32'({tgt_rstr, tgt_wstr}), 32'd0);
    chk("reset err_count", 32'(err_count), 32'd0);
    axilRstN = 1'b1;

    tgt_din[32*2 +: 32] = 32'h12345678;
    run(1, 2, 3, 0, 0, 0, 0, 0);                    // OKAY read, rvalid@5
    run(1, 6, 0, 0, 0, 0, 0, 0);                    // DECERR read
    run(0, 0, 0, 0, 1, 0, NOACK, 2);                // write timeout SLVERR
    run(1, 1, 2, 0, 1, 1, 2, 0);                    // concurrent same target
    run(1, 7, 0, 1, 1, 5, 0, 0);                    // two DECERRs on one edge
    run(1, 4, TIMEOUT - 1, 10, 0, 0, 0, 0);         // ack on the timeout cycle, long hold

    // Reset in the middle of a read.
    @(negedge axilClk);
    m.rstart = 1'b1; m.raddr = mkaddr(3); tgt_rack = '0; tgt_wack = '0;
    @(negedge axilClk);
    m.rstart = 1'b0;
    chk("mid-reset strobe before", 32'(tgt_rstr), 32'h8);
    @(negedge axilClk);
    axilRstN = 1'b0;
    @(negedge axilClk);
    chk("mid-reset strobe dropped", 32'(tgt_rstr), 32'd0);
    chk("mid-reset no rvalid", 32'(m.rvalid), 32'd0);
    chk("mid-reset err_count", 32'(err_count), 32'd0);
    exp_err = 0;
    axilRstN = 1'b1;
    @(negedge axilClk);
    chk("post-reset idle", 32'({tgt_rstr, m.rvalid}), 32'd0);
    run(1, 3, 1, 0, 0, 0, 0, 0);

    for (int it = 0; it < 40; it++) begin
      bit ren, wen;
      for (int i = 0; i < NUM_TGT; i++) tgt_din[32*i +: 32] = $urandom;
      ren = 1'($urandom_range(0, 1));
      wen = 1'($urandom_range(0, 1));
      if (!ren && !wen) ren = 1'b1;
      run(ren, $urandom_range(0, 7), $urandom_range(0, TIMEOUT + 2), $urandom_range(0, 3),
          wen, $urandom_range(0, 7), $urandom_range(0, TIMEOUT + 2), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
